fan_ctrl: RTL

FAN_CTRL -- requirements
Module: fan_ctrl

---
 rtl/fan_ctrl_if.sv | 15 +
 rtl/fan_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fan_ctrl_if.sv
// Register bus between a host and fan_ctrl: strobe/write request, one-cycle ack
// with registered read data.
interface fan_ctrl_if;
  logic        FAN_STB_I;
  logic        FAN_WE_I;
  logic [5:0]  FAN_ADR_I;
  logic [31:0] FAN_DAT_I;
  logic        FAN_ACK_O;
  logic [31:0] FAN_DAT_O;

  modport master (output FAN_STB_I, FAN_WE_I, FAN_ADR_I, FAN_DAT_I,
                  input  FAN_ACK_O, FAN_DAT_O);
  modport slave  (input  FAN_STB_I, FAN_WE_I, FAN_ADR_I, FAN_DAT_I,
                  output FAN_ACK_O, FAN_DAT_O);
endinterface

// File: rtl/fan_ctrl.sv
// Multi-channel fan controller: double-buffered PWM, per-second tach counting, stall IRQ.
// Optional FAN_CTRL_DEBOUNCE_EN adds a 16-sample debounce on each tach input.
module fan_ctrl #(
  parameter int NCH     = 4,
  parameter int PWM_W   = 10,
  parameter int CNT_W   = 27,
  parameter int SEC_CNT = 49999999
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  fan_ctrl_if.slave      bus,
  input  logic [NCH-1:0] FAN_IN,
  output logic [NCH-1:0] PWM_O,
  output logic           STALL_INT
);
  localparam int PRE_W = (SEC_CNT > 0) ? $clog2(SEC_CNT + 1) : 1;

  logic                       r_ack;
  logic [31:0]                r_dat;
  logic [NCH-1:0][PWM_W-1:0]  r_shadow, r_active;
  logic [PWM_W-1:0]           r_cnt;
  logic [PRE_W-1:0]           r_pre;
  logic [NCH-1:0][CNT_W-1:0]  r_count, r_tach, r_thresh;
  logic [NCH-1:0]             r_stall, r_ie, r_s1, r_s2, r_s3;

  logic                       w_acc, w_wr, w_term;
  logic [3:0]                 w_ch;
  logic [1:0]                 w_reg;
  logic [31:0]                w_rdata;
  logic [NCH-1:0]             w_lvl, w_fall, w_sel, w_set, w_clr;
  logic [NCH-1:0][CNT_W-1:0]  w_new;
  logic                       w_unused;

  assign w_acc  = bus.FAN_STB_I & ~r_ack;
  assign w_wr   = w_acc & bus.FAN_WE_I;
  assign w_ch   = bus.FAN_ADR_I[5:2];
  assign w_reg  = bus.FAN_ADR_I[1:0];
  assign w_term = (r_pre == PRE_W'(SEC_CNT));
  assign w_unused = &{1'b0, bus.FAN_DAT_I};

  assign bus.FAN_ACK_O = r_ack;
  assign bus.FAN_DAT_O = r_dat;
  assign STALL_INT     = |(r_stall & r_ie);

  // Channels >= NCH never match w_sel, so their writes drop and reads return 0.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_sel[g]  = (w_ch == 4'(g));
    assign w_new[g]  = (&r_count[g]) ? r_count[g] : r_count[g] + CNT_W'(w_fall[g]);
    assign w_set[g]  = w_term && (r_thresh[g] != '0) && (w_new[g] < r_thresh[g]);
    assign w_clr[g]  = w_wr && w_sel[g] && (w_reg == 2'd3) && bus.FAN_DAT_I[0];
    assign PWM_O[g]  = (&r_active[g]) | (r_cnt < r_active[g]);
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_sel[i]) begin
        case (w_reg)
          2'd0:    w_rdata = 32'(r_shadow[i]);
          2'd1:    w_rdata = 32'(r_tach[i]);
          2'd2:    w_rdata = 32'(r_thresh[i]);
          default: w_rdata = {30'd0, r_ie[i], r_stall[i]};
        endcase
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= FAN_IN;
      r_s2 <= r_s1;
    end
  end

`ifdef FAN_CTRL_DEBOUNCE_EN
  logic [NCH-1:0][3:0] r_dbc;
  logic [NCH-1:0]      r_db;

  // A new level is accepted only after 16 consecutive samples disagree with the old one.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_dbc <= '0;
      r_db  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_dbc[i] <= '0;
        end else if (r_dbc[i] == 4'd15) begin
          r_db[i]  <= r_s2[i];
          r_dbc[i] <= '0;
        end else begin
          r_dbc[i] <= r_dbc[i] + 4'd1;
        end
      end
    end
  end
  assign w_lvl = r_db;
`else
  assign w_lvl = r_s2;
`endif

  assign w_fall = r_s3 & ~w_lvl;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_pre    <= '0;
      r_count  <= '0;
      r_tach   <= '0;
      r_thresh <= '0;
      r_stall  <= '0;
      r_ie     <= '0;
      r_s3     <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : '0;
      r_cnt <= r_cnt + 1'b1;
      r_pre <= w_term ? '0 : r_pre + 1'b1;
      r_s3  <= w_lvl;
      for (int i = 0; i < NCH; i++) begin
        // Shadow only reaches the output at the period boundary.
        if (&r_cnt) r_active[i] <= r_shadow[i];
        r_count[i] <= w_term ? '0 : w_new[i];
        if (w_term) r_tach[i] <= w_new[i];
        if (w_set[i])      r_stall[i] <= 1'b1;
        else if (w_clr[i]) r_stall[i] <= 1'b0;
        if (w_wr && w_sel[i]) begin
          case (w_reg)
            2'd0:    r_shadow[i] <= bus.FAN_DAT_I[PWM_W-1:0];
            2'd2:    r_thresh[i] <= bus.FAN_DAT_I[CNT_W-1:0];
            2'd3:    r_ie[i]     <= bus.FAN_DAT_I[1];
            default: ;
          endcase
        end
      end
    end
  end
endmodule
